// File: rtl/bias_apply_pkg.sv
// Shared types and sizing helpers for the bias_apply stage.
// Default sizes match the coeff_width / acc_width / kern_s_k_<n> layer macros.
package bias_apply_pkg;

   localparam int unsigned KERN_DEFAULT    = 16;
   localparam int unsigned COEFF_W_DEFAULT = 16;
   localparam int unsigned ACC_W_DEFAULT   = 32;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Index width that stays at least one bit wide for degenerate KERN=1.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bias_apply_sat_add.sv
// Combinational signed accumulator + bias add with saturation to ACC_W bits.
module bias_sat_add #(
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned COEFF_W = 16
) (
   input  logic [ACC_W-1:0]   acc,
   input  logic [COEFF_W-1:0] bias,
   output logic [ACC_W-1:0]   sum
);

   logic [ACC_W:0] wide;

   always_comb begin
      wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - COEFF_W){bias[COEFF_W-1]}}, bias};
      // The two top bits disagree exactly when the result left the ACC_W range.
      if (wide[ACC_W] != wide[ACC_W-1]) begin
         sum = wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
      end else begin
         sum = wide[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/bias_apply.sv
// Loads KERN bias coefficients from a FIFO, then adds the per-channel bias to
// each accumulator word and emits the saturated sum through a one-word output register.
module bias_apply
   import bias_apply_pkg::*;
#(
   parameter int unsigned KERN    = KERN_DEFAULT,
   parameter int unsigned COEFF_W = COEFF_W_DEFAULT,
   parameter int unsigned ACC_W   = ACC_W_DEFAULT
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic [COEFF_W-1:0] bias_V_dout,
   input  logic               bias_V_empty_n,
   output logic               bias_V_read,
   input  logic [ACC_W-1:0]   acc_V_dout,
   input  logic               acc_V_empty_n,
   output logic               acc_V_read,
   output logic [ACC_W-1:0]   output_V_din,
   input  logic               output_V_full_n,
   output logic               output_V_write,
   output logic               busy_load
);

   localparam int unsigned IDX_W = idx_width(KERN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERN - 1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   load_idx;
   logic [IDX_W-1:0]   ch_idx;
   logic [COEFF_W-1:0] coef [KERN];
   logic               out_valid;
   logic               bias_xfer;
   logic               acc_xfer;
   logic               out_xfer;
   logic [ACC_W-1:0]   sum_sat;

   always_comb begin
      state_nxt   = state;
      bias_V_read = 1'b0;
      acc_V_read  = 1'b0;
      busy_load   = 1'b0;
      unique case (state)
         LOAD: begin
            busy_load   = 1'b1;
            bias_V_read = bias_V_empty_n;
            if (bias_V_empty_n && (load_idx == LAST_IDX)) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            // Accept a new word when the register is empty or drains this cycle.
            acc_V_read = acc_V_empty_n && (!out_valid || output_V_full_n);
         end
         default: state_nxt = LOAD;
      endcase
   end

   assign output_V_write = out_valid && output_V_full_n;
   assign bias_xfer      = bias_V_read && bias_V_empty_n;
   assign acc_xfer       = acc_V_read && acc_V_empty_n;
   assign out_xfer       = output_V_write;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state    <= LOAD;
         load_idx <= '0;
      end else begin
         state <= state_nxt;
         if (bias_xfer) begin
            load_idx <= (load_idx == LAST_IDX) ? '0 : load_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int unsigned i = 0; i < KERN; i++) begin
            coef[i] <= '0;
         end
      end else if (bias_xfer) begin
         coef[load_idx] <= bias_V_dout;
      end
   end

   bias_sat_add #(
      .ACC_W   (ACC_W),
      .COEFF_W (COEFF_W)
   ) u_sat_add (
      .acc  (acc_V_dout),
      .bias (coef[ch_idx]),
      .sum  (sum_sat)
   );

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         ch_idx       <= '0;
         out_valid    <= 1'b0;
         output_V_din <= '0;
      end else if (acc_xfer) begin
         output_V_din <= sum_sat;
         out_valid    <= 1'b1;
         ch_idx       <= (ch_idx == LAST_IDX) ? '0 : ch_idx + 1'b1;
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bias_apply.sv
// Directed-vector bench for bias_apply with KERN=4 and behavioural FIFO endpoints.
module tb_bias_apply;

   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic        ap_clk;
   logic        ap_rst;
   logic [15:0] bias_V_dout;
   logic        bias_V_empty_n;
   logic        bias_V_read;
   logic [31:0] acc_V_dout;
   logic        acc_V_empty_n;
   logic        acc_V_read;
   logic [31:0] output_V_din;
   logic        output_V_full_n;
   logic        output_V_write;
   logic        busy_load;

   bias_apply #(
      .KERN    (4),
      .COEFF_W (16),
      .ACC_W   (32)
   ) dut (
      .ap_clk          (ap_clk),
      .ap_rst          (ap_rst),
      .bias_V_dout     (bias_V_dout),
      .bias_V_empty_n  (bias_V_empty_n),
      .bias_V_read     (bias_V_read),
      .acc_V_dout      (acc_V_dout),
      .acc_V_empty_n   (acc_V_empty_n),
      .acc_V_read      (acc_V_read),
      .output_V_din    (output_V_din),
      .output_V_full_n (output_V_full_n),
      .output_V_write  (output_V_write),
      .busy_load       (busy_load)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic [15:0] bias_q [$];
   logic [31:0] acc_q [$];
   logic [31:0] out_q [$];
   int          out_cyc_q [$];
   bit          bubble, full_rand, force_full;
   int          cyc, n_bias_rd, n_acc_in_load, n_bias_in_run, n_wr_in_rst;
   int          n_cmp, n_err;

   // FIFO endpoints: drive at negedge, decide transfers just after, commit at posedge.
   always begin : fifo_emul
      bit          rd_b, rd_a, wr;
      logic [31:0] d;
      @(negedge ap_clk);
      bias_V_empty_n  = !ap_rst && (bias_q.size() > 0) && (!bubble || $urandom_range(2) != 0);
      bias_V_dout     = (bias_q.size() > 0) ? bias_q[0] : '0;
      acc_V_empty_n   = !ap_rst && (acc_q.size() > 0) && (!bubble || $urandom_range(2) != 0);
      acc_V_dout      = (acc_q.size() > 0) ? acc_q[0] : '0;
      output_V_full_n = !force_full && (!full_rand || $urandom_range(2) != 0);
      #1;
      rd_b = bias_V_read && bias_V_empty_n;
      rd_a = acc_V_read && acc_V_empty_n;
      wr   = output_V_write && output_V_full_n;
      d    = output_V_din;
      if (acc_V_read && busy_load) n_acc_in_load++;
      if (bias_V_read && !busy_load) n_bias_in_run++;
      if (ap_rst && output_V_write) n_wr_in_rst++;
      @(posedge ap_clk);
      cyc++;
      if (!ap_rst) begin
         if (rd_b) begin void'(bias_q.pop_front()); n_bias_rd++; end
         if (rd_a) void'(acc_q.pop_front());
         if (wr) begin out_q.push_back(d); out_cyc_q.push_back(cyc); end
      end
   end

   function automatic logic [31:0] ref_out(input int acc, input int bias);
      longint s;
      s = longint'(acc) + longint'(bias);
      if (s > MAXV) return 32'h7FFF_FFFF;
      if (s < MINV) return 32'h8000_0000;
      return s[31:0];
   endfunction

   task automatic do_reset();
      @(posedge ap_clk);
      #2;
      ap_rst = 1'b1;
      bias_q.delete();
      acc_q.delete();
      bubble = 0; full_rand = 0; force_full = 0;
      repeat (2) @(negedge ap_clk);
      #3;
      out_q.delete();
      out_cyc_q.delete();
      n_bias_rd = 0; n_acc_in_load = 0; n_bias_in_run = 0;
      ap_rst = 1'b0;
   endtask

   task automatic wait_outs(input int n, output bit ok);
      ok = 0;
      for (int k = 0; k < 500; k++) begin
         if (out_q.size() >= n) begin ok = 1; return; end
         @(posedge ap_clk);
         #1;
      end
   endtask

   task automatic wait_bias_rd(input int n, output bit ok);
      ok = 0;
      for (int k = 0; k < 500; k++) begin
         if (n_bias_rd >= n) begin ok = 1; return; end
         @(posedge ap_clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (output_V_din !== 32'd0) begin n_err++; $display("FAIL reset_din got %h want 0", output_V_din); end
      n_cmp++; if (output_V_write !== 1'b0) begin n_err++; $display("FAIL reset_write got %b want 0", output_V_write); end
      n_cmp++; if (busy_load !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", busy_load); end
      n_cmp++; if (acc_V_read !== 1'b0) begin n_err++; $display("FAIL reset_acc_read got %b want 0", acc_V_read); end
      do_reset();
   endtask

   task automatic test_load_stream();
      int          b [4] = '{1, -2, 3, -4};
      logic [31:0] exp [5] = '{32'd101, 32'd98, 32'd103, 32'd96, 32'd101};
      bit          ok;
      do_reset();
      foreach (b[i]) bias_q.push_back(16'(b[i]));
      repeat (5) acc_q.push_back(32'd100);
      wait_bias_rd(3, ok);
      n_cmp++; if (!ok || busy_load !== 1'b1) begin n_err++; $display("FAIL busy_after3 got %b want 1 (ok=%0d)", busy_load, ok); end
      wait_bias_rd(4, ok);
      n_cmp++; if (!ok || busy_load !== 1'b0) begin n_err++; $display("FAIL busy_after4 got %b want 0 (ok=%0d)", busy_load, ok); end
      wait_outs(5, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL stream_timeout got %0d outs want 5", out_q.size()); end
      if (ok) begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_q[i] !== exp[i]) begin n_err++; $display("FAIL stream_out[%0d] got %0d want %0d", i, $signed(out_q[i]), $signed(exp[i])); end
         end
         n_cmp++;
         if (out_cyc_q[4] - out_cyc_q[0] != 4) begin n_err++; $display("FAIL throughput got %0d cycles want 4", out_cyc_q[4] - out_cyc_q[0]); end
      end
   endtask

   task automatic test_saturation();
      int          b [4] = '{32767, -1, -2, 0};
      logic [31:0] a [4] = '{32'h7FFF_FFF0, 32'h8000_0000, 32'd5, 32'h1234_5678};
      logic [31:0] exp [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd3, 32'h1234_5678};
      bit          ok;
      do_reset();
      foreach (b[i]) bias_q.push_back(16'(b[i]));
      foreach (a[i]) acc_q.push_back(a[i]);
      wait_outs(4, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL sat_timeout got %0d outs want 4", out_q.size()); end
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_q[i] !== exp[i]) begin n_err++; $display("FAIL sat_out[%0d] got %h want %h", i, out_q[i], exp[i]); end
         end
      end
   endtask

   task automatic test_backpressure();
      int          b [4] = '{1, -2, 3, -4};
      int          a [12];
      logic [31:0] held;
      bit          ok;
      do_reset();
      foreach (b[i]) bias_q.push_back(16'(b[i]));
      for (int i = 0; i < 12; i++) begin a[i] = 1000 + i * 7; acc_q.push_back(32'(a[i])); end
      wait_outs(3, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_start_timeout got %0d outs", out_q.size()); end
      force_full = 1;
      @(negedge ap_clk);
      #2;
      held = output_V_din;
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (output_V_write !== 1'b0 || acc_V_read !== 1'b0 || output_V_din !== held) begin
            n_err++;
            $display("FAIL bp_stall[%0d] got wr=%b rd=%b din=%0d want wr=0 rd=0 din=%0d", k, output_V_write, acc_V_read, output_V_din, held);
         end
         @(negedge ap_clk);
         #2;
      end
      force_full = 0;
      wait_outs(12, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout got %0d outs want 12", out_q.size()); end
      if (ok) begin
         for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (out_q[i] !== ref_out(a[i], b[i % 4])) begin n_err++; $display("FAIL bp_out[%0d] got %0d want %0d", i, $signed(out_q[i]), $signed(ref_out(a[i], b[i % 4]))); end
         end
      end
   endtask

   task automatic test_bubbly();
      int b [4] = '{100, -200, 32767, -32768};
      int a [16];
      bit ok;
      do_reset();
      bubble = 1; full_rand = 1;
      foreach (b[i]) bias_q.push_back(16'(b[i]));
      for (int i = 0; i < 14; i++) a[i] = i * 123457 - 1000000;
      a[14] = 32'h7FFF_FF00;
      a[15] = 32'h8000_0010;
      foreach (a[i]) acc_q.push_back(32'(a[i]));
      wait_outs(16, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bub_timeout got %0d outs want 16", out_q.size()); end
      if (ok) begin
         for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (out_q[i] !== ref_out(a[i], b[i % 4])) begin n_err++; $display("FAIL bub_out[%0d] got %h want %h", i, out_q[i], ref_out(a[i], b[i % 4])); end
         end
      end
      n_cmp++; if (n_acc_in_load != 0) begin n_err++; $display("FAIL acc_read_in_load got %0d want 0", n_acc_in_load); end
   endtask

   task automatic test_reset_mid();
      int b2 [4] = '{10, 20, 30, 40};
      int b3 [4] = '{-1, -2, -3, -4};
      int e2 [6] = '{10, 20, 30, 40, 10, 20};
      bit ok;
      do_reset();
      n_wr_in_rst = 0;
      bias_q.push_back(16'd5);
      bias_q.push_back(16'd6);
      wait_bias_rd(2, ok);
      repeat (3) @(posedge ap_clk);
      #1;
      n_cmp++; if (!ok || busy_load !== 1'b1) begin n_err++; $display("FAIL midload_busy got %b want 1 (ok=%0d)", busy_load, ok); end
      do_reset();
      foreach (b2[i]) bias_q.push_back(16'(b2[i]));
      repeat (6) acc_q.push_back(32'd0);
      wait_outs(6, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL reload_timeout got %0d outs want 6", out_q.size()); end
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_q[i] !== 32'(e2[i])) begin n_err++; $display("FAIL reload_out[%0d] got %0d want %0d", i, $signed(out_q[i]), e2[i]); end
         end
      end
      do_reset();
      foreach (b3[i]) bias_q.push_back(16'(b3[i]));
      acc_q.push_back(32'd50);
      acc_q.push_back(32'd50);
      wait_outs(2, ok);
      repeat (8) @(posedge ap_clk);
      #1;
      n_cmp++; if (!ok || out_q.size() != 2) begin n_err++; $display("FAIL midrun_count got %0d want 2", out_q.size()); end
      if (ok) begin
         n_cmp++; if (out_q[0] !== 32'd49) begin n_err++; $display("FAIL midrun_first got %0d want 49", $signed(out_q[0])); end
         n_cmp++; if (out_q[1] !== 32'd48) begin n_err++; $display("FAIL midrun_second got %0d want 48", $signed(out_q[1])); end
      end
      n_cmp++; if (n_wr_in_rst != 0) begin n_err++; $display("FAIL write_in_reset got %0d want 0", n_wr_in_rst); end
   endtask

   task automatic test_extra_bias();
      int b [6] = '{1, 2, 3, 4, 99, 98};
      bit ok;
      do_reset();
      foreach (b[i]) bias_q.push_back(16'(b[i]));
      repeat (4) acc_q.push_back(32'd0);
      wait_outs(4, ok);
      repeat (10) @(posedge ap_clk);
      #1;
      n_cmp++; if (!ok) begin n_err++; $display("FAIL extra_timeout got %0d outs want 4", out_q.size()); end
      n_cmp++; if (n_bias_rd != 4) begin n_err++; $display("FAIL extra_reads got %0d want 4", n_bias_rd); end
      n_cmp++; if (bias_q.size() != 2) begin n_err++; $display("FAIL extra_left got %0d want 2", bias_q.size()); end
      n_cmp++; if (n_bias_in_run != 0) begin n_err++; $display("FAIL bias_read_in_run got %0d want 0", n_bias_in_run); end
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_q[i] !== 32'(b[i])) begin n_err++; $display("FAIL extra_out[%0d] got %0d want %0d", i, $signed(out_q[i]), b[i]); end
         end
      end
   endtask

   initial begin
      ap_rst = 1'b1;
      bubble = 0; full_rand = 0; force_full = 0;
      cyc = 0; n_bias_rd = 0; n_acc_in_load = 0; n_bias_in_run = 0; n_wr_in_rst = 0;
      n_cmp = 0; n_err = 0;
      bias_V_dout = '0; bias_V_empty_n = 1'b0;
      acc_V_dout = '0; acc_V_empty_n = 1'b0;
      output_V_full_n = 1'b1;
      test_reset();
      test_load_stream();
      test_saturation();
      test_backpressure();
      test_bubbly();
      test_reset_mid();
      test_extra_bias();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
